// File: rtl/ddr_axi_arbiter.sv
// rtl/ddr_axi_arbiter.sv - per-burst round-robin share of one DDR AXI port between N_WR writers and one reader
// Define DDR_ARB_RD_PRIO_EN to give the reader absolute priority over the writers.
module ddr_axi_arbiter #(
  parameter int N_WR      = 2,
  parameter int BURST_LEN = 16,
  parameter int ADDR_W    = 28
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   ddr_inited,
  input  logic [N_WR-1:0]        wr_req,
  input  logic [N_WR*ADDR_W-1:0] wr_addr,
  input  logic [N_WR*256-1:0]    wr_data,
  output logic [N_WR-1:0]        wr_gnt,
  output logic [N_WR-1:0]        wr_data_rd,
  input  logic                   rd_req,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic                   rd_gnt,
  output logic [255:0]           rd_data,
  output logic                   rd_valid,
  output logic                   rd_last,
  output logic [ADDR_W-1:0]      axi_awaddr,
  output logic                   axi_awuser_ap,
  output logic [3:0]             axi_awuser_id,
  output logic [7:0]             axi_awlen,
  output logic                   axi_awvalid,
  input  logic                   axi_awready,
  output logic [255:0]           axi_wdata,
  output logic [31:0]            axi_wstrb,
  input  logic                   axi_wready,
  input  logic                   axi_wusero_last,
  output logic [ADDR_W-1:0]      axi_araddr,
  output logic                   axi_aruser_ap,
  output logic [3:0]             axi_aruser_id,
  output logic [7:0]             axi_arlen,
  output logic                   axi_arvalid,
  input  logic                   axi_arready,
  input  logic [255:0]           axi_rdata,
  input  logic [3:0]             axi_rid,
  input  logic                   axi_rlast,
  input  logic                   axi_rvalid,
  output logic                   err
);

  localparam int         N_REQ     = N_WR + 1;
  localparam logic [7:0] LEN       = 8'(BURST_LEN - 1);
  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);
  localparam logic [3:0] RD_ID     = 4'(N_WR);

  typedef enum logic [2:0] {S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_DATA} state_t;

  state_t            r_state;
  logic [3:0]        r_owner, r_rr_ptr, r_beat;
  logic              r_awvalid, r_arvalid, r_awap, r_arap, r_err;
  logic [ADDR_W-1:0] r_awaddr, r_araddr;
  logic [3:0]        r_awid, r_arid;
  logic [7:0]        r_awlen, r_arlen;

  logic [N_REQ-1:0]  w_req;
  logic [4:0]        w_pick;
  logic [3:0]        w_rr_next;
  logic [ADDR_W-1:0] w_sel_addr;

  // Returns {found, index}: nearest requester at or after ptr, wrapping at n.
  function automatic logic [4:0] rr_pick(input logic [N_REQ-1:0] req, input logic [3:0] ptr,
                                         input int n);
    int best, d;
    rr_pick = '0;
    best    = n;
    for (int j = 0; j < N_REQ; j++) begin
      d = (j >= int'(ptr)) ? j - int'(ptr) : j + n - int'(ptr);
      if (j < n && req[j] && d < best) begin
        best    = d;
        rr_pick = {1'b1, 4'(j)};
      end
    end
  endfunction

  assign w_req = {rd_req, wr_req};

`ifdef DDR_ARB_RD_PRIO_EN
  assign w_pick    = rd_req ? {1'b1, RD_ID} : rr_pick(w_req, r_rr_ptr, N_WR);
  assign w_rr_next = (r_owner == RD_ID) ? r_rr_ptr :
                     ((int'(r_owner) + 1 >= N_WR) ? 4'd0 : r_owner + 4'd1);
`else
  assign w_pick    = rr_pick(w_req, r_rr_ptr, N_REQ);
  assign w_rr_next = (int'(r_owner) + 1 >= N_REQ) ? 4'd0 : r_owner + 4'd1;
`endif

  always_comb begin
    axi_wdata  = '0;
    wr_data_rd = '0;
    wr_gnt     = '0;
    w_sel_addr = '0;
    for (int j = 0; j < N_WR; j++) begin
      if (r_owner == 4'(j)) begin
        if (r_state == S_WR_DATA) begin
          axi_wdata     = wr_data[j*256 +: 256];
          wr_data_rd[j] = axi_wready;
        end
        if (r_state == S_WR_ADDR) wr_gnt[j] = axi_awready;
      end
      if (w_pick[3:0] == 4'(j)) w_sel_addr = wr_addr[j*ADDR_W +: ADDR_W];
    end
  end

  assign axi_wstrb = (r_state == S_WR_DATA) ? '1 : '0;
  assign rd_gnt    = (r_state == S_RD_ADDR) & axi_arready;
  assign rd_valid  = (r_state == S_RD_DATA) & axi_rvalid;
  assign rd_last   = rd_valid & axi_rlast;
  assign rd_data   = (r_state == S_RD_DATA) ? axi_rdata : '0;

  assign axi_awaddr    = r_awaddr;
  assign axi_awuser_ap = r_awap;
  assign axi_awuser_id = r_awid;
  assign axi_awlen     = r_awlen;
  assign axi_awvalid   = r_awvalid;
  assign axi_araddr    = r_araddr;
  assign axi_aruser_ap = r_arap;
  assign axi_aruser_id = r_arid;
  assign axi_arlen     = r_arlen;
  assign axi_arvalid   = r_arvalid;
  assign err           = r_err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_owner   <= '0;
      r_rr_ptr  <= '0;
      r_beat    <= '0;
      r_awvalid <= 1'b0;
      r_arvalid <= 1'b0;
      r_awap    <= 1'b0;
      r_arap    <= 1'b0;
      r_err     <= 1'b0;
      r_awaddr  <= '0;
      r_araddr  <= '0;
      r_awid    <= '0;
      r_arid    <= '0;
      r_awlen   <= '0;
      r_arlen   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_beat <= '0;
          if (ddr_inited && w_pick[4]) begin
            r_owner <= w_pick[3:0];
            if (w_pick[3:0] == RD_ID) begin
              r_state   <= S_RD_ADDR;
              r_arvalid <= 1'b1;
              r_araddr  <= rd_addr;
              r_arid    <= RD_ID;
              r_arlen   <= LEN;
              r_arap    <= 1'b1;
            end else begin
              r_state   <= S_WR_ADDR;
              r_awvalid <= 1'b1;
              r_awaddr  <= w_sel_addr;
              r_awid    <= w_pick[3:0];
              r_awlen   <= LEN;
              r_awap    <= 1'b1;
            end
          end
        end
        S_WR_ADDR: if (axi_awready) begin
          r_awvalid <= 1'b0;
          r_state   <= S_WR_DATA;
        end
        S_WR_DATA: if (axi_wready) begin
          r_beat <= r_beat + 4'd1;
          if (axi_wusero_last && r_beat != LAST_BEAT) r_err <= 1'b1;
          if (r_beat == LAST_BEAT) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= w_rr_next;
          end
        end
        S_RD_ADDR: if (axi_arready) begin
          r_arvalid <= 1'b0;
          r_state   <= S_RD_DATA;
        end
        S_RD_DATA: if (axi_rvalid) begin
          r_beat <= r_beat + 4'd1;
          if (axi_rid != RD_ID || (axi_rlast && r_beat != LAST_BEAT)) r_err <= 1'b1;
          if (axi_rlast) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= w_rr_next;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_axi_arbiter.sv
// tb/tb_ddr_axi_arbiter.sv - directed self-checking bench for ddr_axi_arbiter
module tb_ddr_axi_arbiter;

  logic         clk = 1'b0;
  logic         rstn, ddr_inited;
  logic [1:0]   wr_req, wr_gnt, wr_data_rd;
  logic [55:0]  wr_addr;
  logic [511:0] wr_data;
  logic         rd_req, rd_gnt, rd_valid, rd_last;
  logic [27:0]  rd_addr, axi_awaddr, axi_araddr;
  logic [255:0] rd_data, axi_wdata, axi_rdata;
  logic         axi_awuser_ap, axi_awvalid, axi_awready, axi_wready, axi_wusero_last;
  logic [3:0]   axi_awuser_id, axi_aruser_id, axi_rid;
  logic [7:0]   axi_awlen, axi_arlen;
  logic [31:0]  axi_wstrb;
  logic         axi_aruser_ap, axi_arvalid, axi_arready, axi_rlast, axi_rvalid, err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ddr_axi_arbiter dut (
    .clk(clk), .rstn(rstn), .ddr_inited(ddr_inited),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_gnt(wr_gnt), .wr_data_rd(wr_data_rd),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .axi_awaddr(axi_awaddr), .axi_awuser_ap(axi_awuser_ap), .axi_awuser_id(axi_awuser_id),
    .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wready(axi_wready),
    .axi_wusero_last(axi_wusero_last),
    .axi_araddr(axi_araddr), .axi_aruser_ap(axi_aruser_ap), .axi_aruser_id(axi_aruser_id),
    .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rid(axi_rid), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
    .err(err)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt, left, n_gnt, bb, guard;
    int got [6];
    int exp_order [6];
    logic [31:0] rd32;

`ifdef DDR_ARB_RD_PRIO_EN
    exp_order = '{2, 2, 2, 2, 2, 2};
`else
    exp_order = '{0, 1, 2, 0, 1, 2};
`endif
    rstn = 1'b0; ddr_inited = 1'b0;
    wr_req = '0; wr_addr = '0; rd_req = 1'b0; rd_addr = '0;
    wr_data = {{8{32'hBBBB_0001}}, {8{32'hAAAA_0000}}};
    axi_awready = 1'b0; axi_wready = 1'b0; axi_wusero_last = 1'b0; axi_arready = 1'b0;
    axi_rdata = '0; axi_rid = '0; axi_rlast = 1'b0; axi_rvalid = 1'b0;

    repeat (2) tick();
    chk("rst_awvalid", axi_awvalid, 1'b0);
    chk("rst_arvalid", axi_arvalid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_wr_data_rd", wr_data_rd, 2'b00);
    chk("rst_rd_valid", rd_valid, 1'b0);
    rstn = 1'b1;

    // DDR not calibrated: requests must not produce any address valid
    wr_req = 2'b11; rd_req = 1'b1;
    repeat (4) begin
      tick();
      chk("uninit_valid", {axi_awvalid, axi_arvalid}, 2'b00);
    end
    wr_req = '0; rd_req = 1'b0; ddr_inited = 1'b1;
    tick();

    // Single write burst from writer 0
    wr_addr = {28'h0, 28'h0000100}; wr_req = 2'b01; axi_awready = 1'b1; axi_wready = 1'b1;
    tick();
    chk("t1_awvalid", axi_awvalid, 1'b1);
    chk("t1_awaddr", axi_awaddr, 28'h0000100);
    chk("t1_awlen", axi_awlen, 8'd15);
    chk("t1_awuser_id", axi_awuser_id, 4'd0);
    chk("t1_awuser_ap", axi_awuser_ap, 1'b1);
    chk("t1_wr_gnt", wr_gnt, 2'b01);
    wr_req = '0;
    cnt = 0;
    repeat (20) begin
      tick();
      if (wr_data_rd[0]) begin
        if (cnt == 0) begin
          chk("t1_wdata", axi_wdata, {8{32'hAAAA_0000}});
          chk("t1_wstrb", axi_wstrb, 32'hFFFF_FFFF);
        end
        cnt++;
      end
      chk("t1_wr_data_rd1", wr_data_rd[1], 1'b0);
    end
    chk("t1_beats", cnt, 16);
    chk("t1_idle_awvalid", axi_awvalid, 1'b0);
    chk("t1_err", err, 1'b0);
    axi_awready = 1'b0; axi_wready = 1'b0;

    // Read burst with AR back-pressure for five cycles
    rd_addr = 28'h0400000; rd_req = 1'b1;
    tick();
    chk("t3_arlen", axi_arlen, 8'd15);
    chk("t3_aruser_id", axi_aruser_id, 4'd2);
    chk("t3_aruser_ap", axi_aruser_ap, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_ar_hold", {axi_arvalid, rd_gnt, axi_araddr}, {1'b1, 1'b0, 28'h0400000});
      if (i < 4) tick();
    end
    tick();
    axi_arready = 1'b1;
    #1;
    chk("t3_rd_gnt", rd_gnt, 1'b1);
    rd_req = 1'b0;
    tick();
    axi_arready = 1'b0;
    for (int b = 0; b < 17; b++) begin
      if (b == 8) begin
        axi_rvalid = 1'b0; axi_rlast = 1'b0;
        #1;
        chk("t3_stall_valid", rd_valid, 1'b0);
      end else begin
        bb = (b > 8) ? b - 1 : b;
        rd32 = 32'hD000_0000 + 32'(bb);
        axi_rvalid = 1'b1; axi_rid = 4'd2; axi_rdata = {8{rd32}}; axi_rlast = (bb == 15);
        #1;
        chk("t3_rd_valid", rd_valid, 1'b1);
        chk("t3_rd_data", rd_data, {8{rd32}});
        chk("t3_rd_last", rd_last, (bb == 15));
      end
      tick();
    end
    axi_rvalid = 1'b0; axi_rlast = 1'b0;
    #1;
    chk("t3_post_valid", rd_valid, 1'b0);
    chk("t3_err", err, 1'b0);

    // All three requesters held: check grant order
    axi_awready = 1'b1; axi_wready = 1'b1; axi_arready = 1'b1;
    wr_req = 2'b11; rd_req = 1'b1;
    n_gnt = 0; left = 0;
    for (int cyc = 0; cyc < 400 && !(n_gnt == 6 && left == 0); cyc++) begin
      tick();
      if (left > 0) begin
        axi_rvalid = 1'b1; axi_rid = 4'd2; axi_rlast = (left == 1); left--;
      end else begin
        axi_rvalid = 1'b0; axi_rlast = 1'b0;
      end
      if (n_gnt < 6 && (wr_gnt != 2'b00 || rd_gnt)) begin
        got[n_gnt] = rd_gnt ? 2 : (wr_gnt[1] ? 1 : 0);
        if (rd_gnt) left = 16;
        n_gnt++;
        if (n_gnt == 6) begin
          wr_req = '0; rd_req = 1'b0;
        end
      end
    end
    tick();
    axi_rvalid = 1'b0; axi_rlast = 1'b0;
    chk("t2_grants", n_gnt, 6);
    for (int i = 0; i < 6; i++) chk("t2_order", got[i], exp_order[i]);
    repeat (20) tick();
    chk("t2_err", err, 1'b0);
    axi_arready = 1'b0;

    // Early wusero_last on beat 9 sets sticky err, burst still 16 beats
    wr_req = 2'b01;
    tick();
    wr_req = '0;
    cnt = 0;
    repeat (20) begin
      tick();
      axi_wusero_last = 1'b0;
      if (wr_data_rd[0]) begin
        if (cnt == 9) begin
          chk("t4_err_before", err, 1'b0);
          axi_wusero_last = 1'b1;
        end
        cnt++;
      end
    end
    axi_wusero_last = 1'b0;
    chk("t4_beats", cnt, 16);
    chk("t4_err", err, 1'b1);
    repeat (3) tick();
    chk("t4_err_sticky", err, 1'b1);

    // Reset asserted during writer 1 beat 7
    wr_req = 2'b10;
    tick();
    chk("t5_awuser_id", axi_awuser_id, 4'd1);
    chk("t5_wr_gnt", wr_gnt, 2'b10);
    wr_req = '0;
    cnt = 0; guard = 0;
    while (guard < 20) begin
      tick();
      guard++;
      if (wr_data_rd[1]) begin
        if (cnt == 7) break;
        cnt++;
      end
    end
    chk("t5_reached_beat7", cnt, 7);
    rstn = 1'b0;
    #1;
    chk("t5_rst_outs", {axi_awvalid, axi_arvalid, wr_data_rd, wr_gnt, err, rd_valid}, '0);
    chk("t5_rst_wdata", axi_wdata, '0);
    chk("t5_rst_wstrb", axi_wstrb, 32'h0);
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    chk("t5_idle", axi_awvalid, 1'b0);
    wr_req = 2'b11;
    tick();
    chk("t5_rr_reset_id", axi_awuser_id, 4'd0);
    chk("t5_rr_reset_gnt", wr_gnt, 2'b01);
    wr_req = '0;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
